// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst write arbiter for a shared byte FIFO
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic                    fifo_full,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic                    fifo_wn,
  output logic [DATA_W-1:0]       fifo_data,
  output logic [ID_W-1:0]         owner_id,
  output logic                    busy
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]       state;
  logic [ID_W-1:0]  owner;
  logic [ID_W-1:0]  last_owner;
  logic [CNT_W-1:0] burst_cnt;

  logic [ID_W-1:0]  pick_base;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  cand;
  logic             owner_req;
  logic             beat;
  logic             limit_rel;
  logic             drop_rel;
  logic             release_now;
  logic             any_req;

  assign busy        = (state == BURST);
  assign any_req     = |req;
  assign beat        = busy & owner_req & ~fifo_full;
  assign limit_rel   = beat & (burst_cnt == CNT_W'(MAX_BURST - 1));
  assign drop_rel    = busy & ~owner_req;
  assign release_now = limit_rel | drop_rel;
  assign fifo_wn     = beat;
  assign owner_id    = busy ? owner : '0;

  // On a release the search must already start after the outgoing owner.
  assign pick_base = release_now ? owner : last_owner;

  always_comb begin
    pick = pick_base;
    cand = pick_base;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(pick_base) + i) % N_REQ);
      if (req[cand]) pick = cand;
    end
  end

  always_comb begin
    owner_req = 1'b0;
    gnt       = '0;
    ack       = '0;
    fifo_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner == ID_W'(k)) begin
        owner_req = req[k];
        gnt[k]    = busy;
        ack[k]    = beat;
        if (busy) fifo_data = data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      burst_cnt  <= '0;
      last_owner <= ID_W'(N_REQ - 1);
    end else if (!busy) begin
      if (any_req) begin
        state     <= BURST;
        owner     <= pick;
        burst_cnt <= '0;
      end
    end else if (release_now) begin
      last_owner <= owner;
      if (any_req) begin
        owner     <= pick;
        burst_cnt <= '0;
      end else begin
        state <= IDLE;
      end
    end else if (beat) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req, gnt, ack;
  logic [N*DW-1:0] data_in;
  logic          fifo_full, fifo_wn, busy;
  logic [DW-1:0] fifo_data;
  logic [1:0]    owner_id;

  logic [N-1:0]  req_b, gnt_b, ack_b;
  logic [N*DW-1:0] data_b;
  logic          full_b, wn_b, busy_b;
  logic [DW-1:0] fifo_data_b;
  logic [1:0]    owner_b;

  always #5 clock = ~clock;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset), .req(req), .data_in(data_in),
    .fifo_full(fifo_full), .gnt(gnt), .ack(ack), .fifo_wn(fifo_wn),
    .fifo_data(fifo_data), .owner_id(owner_id), .busy(busy)
  );

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(1)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .data_in(data_b),
    .fifo_full(full_b), .gnt(gnt_b), .ack(ack_b), .fifo_wn(wn_b),
    .fifo_data(fifo_data_b), .owner_id(owner_b), .busy(busy_b)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_q[$];
  int exp_qb[$];
  int rem[N];
  int seq[N];
  logic [7:0] base[N];

  logic [N-1:0] gnt_s, ack_s;
  logic         wn_s, busy_s;
  logic [1:0]   cnt_s, owner_s;
  logic [7:0]   data_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void push(int id, int d);
    exp_q.push_back(id * 256 + d);
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req[k] = (rem[k] > 0);
      data_in[k*DW +: DW] = base[k] + 8'(seq[k]);
    end
  endtask

  task automatic load(input int k, input logic [7:0] b, input int n);
    base[k] = b;
    seq[k]  = 0;
    rem[k]  = n;
  endtask

  // Sample mid-cycle, then let producers retire acked beats after the edge.
  task automatic tick();
    @(negedge clock);
    gnt_s = gnt; ack_s = ack; wn_s = fifo_wn; busy_s = busy;
    cnt_s = dut.burst_cnt; owner_s = owner_id; data_s = fifo_data;
    @(posedge clock);
    #1;
    for (int k = 0; k < N; k++)
      if (ack_s[k]) begin
        rem[k]--;
        seq[k]++;
      end
    drive();
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int k = 0; k < N; k++) if (rem[k] > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_done();
    int c = 0;
    while (pending() && c < 200) begin
      tick();
      c++;
    end
    check("done_in_time", {31'b0, c < 200}, 32'd1);
  endtask

  always @(negedge clock) begin
    if (fifo_wn) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd0, 32'd1);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("write_id_data", {22'b0, owner_id, fifo_data}, e);
        check("write_ack", {28'b0, ack}, 32'd1 << e[9:8]);
        check("write_not_full", {31'b0, fifo_full}, 32'd0);
      end
    end
  end

  always @(negedge clock) begin
    if (wn_b) begin
      if (exp_qb.size() == 0) begin
        check("b_unexpected_write", 32'd0, 32'd1);
      end else begin
        int e;
        e = exp_qb.pop_front();
        check("b_write_id_data", {22'b0, owner_b, fifo_data_b}, e);
        check("b_write_ack", {28'b0, ack_b}, 32'd1 << e[9:8]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nwr;
    reset = 1'b1;
    fifo_full = 1'b0;
    for (int k = 0; k < N; k++) load(k, 8'h00, 0);
    drive();
    req_b = '0;
    full_b = 1'b0;
    for (int k = 0; k < N; k++) data_b[k*DW +: DW] = 8'(8'hA0 + k * 8'h11);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    tick();
    check("reset_gnt", gnt_s, 0);
    check("reset_busy_wn", {busy_s, wn_s, ack_s}, 0);
    check("reset_owner_data", {owner_s, data_s}, 0);

    // all four requesters, 4 beats each
    for (int k = 0; k < N; k++) begin
      load(k, 8'(k * 32), 4);
      for (int b = 0; b < 4; b++) push(k, k * 32 + b);
    end
    drive();
    tick();
    check("grant_latency_idle", gnt_s, 0);
    nwr = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) check("first_grant", gnt_s, 4'b0001);
      if (i == 4) check("handover_gnt1", gnt_s, 4'b0010);
      nwr += int'(wn_s);
    end
    check("continuous_writes", nwr, 16);
    wait_done();

    // sole requester re-granted after limit release
    load(0, 8'h10, 6);
    for (int b = 0; b < 6; b++) push(0, 8'h10 + b);
    drive();
    tick();
    nwr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nwr += int'(wn_s);
    end
    check("sole_regrant_writes", nwr, 6);
    tick();
    check("drop_cycle_no_write", {busy_s, wn_s}, 2'b10);
    tick();
    check("idle_after_drop", {busy_s, gnt_s}, 0);

    // full stall in the middle of requester 1's burst
    load(1, 8'h30, 4);
    for (int b = 0; b < 4; b++) push(1, 8'h30 + b);
    drive();
    repeat (3) tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_write", {wn_s, ack_s}, 0);
      check("stall_gnt_held", gnt_s, 4'b0010);
      check("stall_cnt_held", cnt_s, 2);
    end
    fifo_full = 1'b0;
    wait_done();
    repeat (2) tick();

    // requester 2 drops after one beat, 3 pending
    load(2, 8'h40, 1);
    load(3, 8'h50, 2);
    push(2, 8'h40); push(3, 8'h50); push(3, 8'h51);
    drive();
    tick();
    tick();
    check("drop_owner_gnt", gnt_s, 4'b0100);
    tick();
    check("drop_no_write", {wn_s, ack_s}, 0);
    tick();
    check("after_drop_gnt", gnt_s, 4'b1000);
    check("after_drop_cnt", cnt_s, 0);
    wait_done();
    repeat (2) tick();

    // reset in the middle of requester 1's burst
    load(1, 8'h70, 8);
    push(1, 8'h70); push(1, 8'h71); push(1, 8'h72);
    drive();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("pre_reset_state", {gnt_s, 2'b0, cnt_s}, {4'b0010, 2'b0, 2'd2});
    reset = 1'b0;
    load(1, 8'h90, 1);
    load(0, 8'h80, 1);
    push(0, 8'h80); push(1, 8'h90);
    drive();
    tick();
    check("post_reset_idle", {gnt_s, wn_s, busy_s}, 0);
    tick();
    check("post_reset_rr_gnt", gnt_s, 4'b0001);
    wait_done();
    repeat (2) tick();

    // MAX_BURST=1 instance: two requesters alternate every cycle
    exp_qb.push_back(0 * 256 + 8'hA0);
    exp_qb.push_back(2 * 256 + 8'hC2);
    exp_qb.push_back(0 * 256 + 8'hA0);
    exp_qb.push_back(2 * 256 + 8'hC2);
    req_b = 4'b0101;
    @(negedge clock);
    check("b_latency_idle", gnt_b, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("b_alternate_gnt", gnt_b, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      check("b_write_each_cycle", {31'b0, wn_b}, 32'd1);
    end
    @(posedge clock);
    #1 req_b = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("b_idle_end", {busy_b, gnt_b}, 0);

    check("queues_drained", exp_q.size() + exp_qb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single 8-entry byte FIFO among N_REQ producers. It grants one requester at a time for a bounded burst and drives the FIFO write port (wn, data_in). It watches the FIFO full flag so that no write is attempted while the FIFO is full. The block sits between the producer blocks and the FIFO write side; the read side is untouched.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width; must match the FIFO data width
MAX_BURST, 4, maximum accepted beats per grant (>=1)
ID_W, clog2(N_REQ) (derived, min 1), width of owner_id

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester write request; held high while data is valid
data_in  in  N_REQ*DATA_W  requester k's data occupies bits [k*DATA_W +: DATA_W]
fifo_full  in  1  FIFO full flag
gnt  out  N_REQ  one-hot registered grant; all zero when idle
ack  out  N_REQ  one-hot beat accepted this cycle (combinational)
fifo_wn  out  1  FIFO write enable (combinational)
fifo_data  out  DATA_W  FIFO write data; owner's data when granted, else 0
owner_id  out  ID_W  index of the current owner; 0 when idle
busy  out  1  high in state BURST

Behaviour:
- States: IDLE, BURST. Registers: state, owner, burst_cnt (counts 0..MAX_BURST-1), last_owner.
- Reset (synchronous, evaluated at the clock edge, overrides everything): state=IDLE, burst_cnt=0, last_owner=N_REQ-1. After reset, gnt=0, ack=0, fifo_wn=0, fifo_data=0, owner_id=0, busy=0. Any burst in progress is abandoned with no further writes. Beats already written stay in the FIFO.
- Round-robin pick: search req starting at index (last_owner+1) mod N_REQ and wrap. The first index with req high wins.
- IDLE:
  - If any req is high, register the winner as owner, set burst_cnt=0 and go to BURST.
  - Grant latency is 1 cycle: req rises at cycle t, gnt is high at cycle t+1.
  - No writes occur in IDLE.
- beat = busy & req[owner] & ~fifo_full.
  - fifo_wn = beat.
  - ack[owner] = beat.
  - fifo_data = data_in slice of owner while busy, else 0.
- BURST, evaluated each cycle:
  - fifo_full=1 and req[owner]=1: stall. No beat; owner, burst_cnt and grant are held. There is no timeout.
  - beat and burst_cnt < MAX_BURST-1: burst_cnt++ and stay.
  - beat and burst_cnt == MAX_BURST-1: limit release. Set last_owner=owner, then re-pick including this cycle's req.
  - req[owner]=0: drop release, with no beat this cycle. Set last_owner=owner, then re-pick.
  - Re-pick: if any req is high, load the new owner and burst_cnt=0 and stay in BURST. This gives a gap-free handover, and the next owner's gnt is high in the very next cycle. If no req is high, go to IDLE.
  - After a limit release, the same requester can win again only if it is the sole requester, because the search starts at owner+1 and wraps.
- Requesters must hold req and data stable until ack. If a requester lowers req while it does not own the grant, it simply loses its place; this is not an error.
- Never more than one gnt bit or ack bit is high. fifo_wn is never high while fifo_full is high.

Test Plan:
- Reset, then req=4'b1111 held for 16 beats (fifo_full=0, MAX_BURST=4) -> gnt order 0,1,2,3, each owner gets exactly 4 consecutive acks. gnt[0] is first high 1 cycle after req, and fifo_wn is continuous with no idle cycle at handovers.
- req0 alone held for 6 beats, data 0x10..0x15 -> writes 0x10..0x13, then req0 is re-granted with no gap and writes 0x14,0x15. Lowering req0 afterwards gives IDLE on the next cycle with busy=0.
- fifo_full=1 for 3 cycles after the 2nd beat of req1's burst -> fifo_wn=0 and ack=0 for those 3 cycles, gnt[1] held, burst_cnt held. The remaining 2 beats complete once full drops.
- req2 lowered after 1 beat while req3 is pending -> on the drop cycle: no write. Next cycle: gnt=4'b1000, burst_cnt=0.
- reset asserted mid-burst (owner 1, burst_cnt=2) -> cycle after: gnt=0, fifo_wn=0, busy=0. With req=4'b0011 held, the next grant goes to requester 0 (last_owner=3 after reset).
- Two requesters, req=4'b0101 with MAX_BURST=1 -> gnt alternates 0,2,0,2 every cycle, with one write per cycle.
